// File: rtl/maverickOne_pkg.sv
// Shared core constants and the write-back request type used by regfile_wb_arbiter.
// Build option REGFILE_WB_FIXED_PRIO_EN is consumed by rr_arbiter.
package maverickOne_pkg;
  localparam int NUM_REGS   = 64;
  localparam int XLEN       = 64;
  localparam int WB_AW      = $clog2(NUM_REGS);
  localparam int WB_NUM_SRC = 4;

  typedef struct packed {
    logic [WB_AW-1:0] addr;
    logic [XLEN-1:0]  data;
  } wb_req_t;
endpackage

// File: rtl/regfile_wb_arbiter_rr.sv
// rr_arbiter: one-hot grant over N requesters, round-robin from a rotating pointer.
// With REGFILE_WB_FIXED_PRIO_EN defined it becomes fixed priority (lowest index wins, no pointer).
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic          clk_i,
  input  logic          arst_i,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

`ifdef REGFILE_WB_FIXED_PRIO_EN
  logic unused_sig;
  assign unused_sig = clk_i ^ arst_i ^ advance;

  always_comb begin
    logic found;
    found   = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < N; k++) begin
      if (!found && req[k]) begin
        found   = 1'b1;
        gnt_idx = IW'(k);
      end
    end
    gnt = found ? (N'(1) << gnt_idx) : '0;
  end
`else
  logic [IW-1:0] ptr;
  int            idx;

  // search ptr, ptr+1, ... wrapping at N
  always_comb begin
    logic found;
    found   = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        found   = 1'b1;
        gnt_idx = IW'(idx);
      end
    end
    gnt = found ? (N'(1) << gnt_idx) : '0;
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      ptr <= '0;
    end else if (advance && (|req)) begin
      ptr <= (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + IW'(1);
    end
  end
`endif

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back initiator: arbitrates NUM_SRC result ports into one registered unlock-write per cycle.
// Define REGFILE_WB_FIXED_PRIO_EN for fixed-priority arbitration instead of round-robin.
module regfile_wb_arbiter
  import maverickOne_pkg::*;
#(
  parameter int NUM_SRC = WB_NUM_SRC,
  localparam int NR = NUM_REGS,
  localparam int DW = XLEN,
  localparam int AW = $clog2(NR),
  localparam int IW = $clog2(NUM_SRC)
) (
  input  logic                  clk_i,
  input  logic                  arst_i,
  input  logic [NUM_SRC-1:0]    src_valid_i,
  output logic [NUM_SRC-1:0]    src_ready_o,
  input  logic [NUM_SRC*AW-1:0] src_addr_i,
  input  logic [NUM_SRC*DW-1:0] src_data_i,
  output logic                  wr_unlock_en_o,
  output logic [AW-1:0]         wr_unlock_addr_o,
  output logic [DW-1:0]         wr_unlock_data_o,
  output logic [IW-1:0]         grant_idx_o
);

  logic [NUM_SRC-1:0] gnt;
  logic [IW-1:0]      gnt_idx;
  logic               transfer;
  wb_req_t            sel;

  rr_arbiter #(.N(NUM_SRC)) u_arb (
    .clk_i   (clk_i),
    .arst_i  (arst_i),
    .req     (src_valid_i),
    .advance (transfer),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // no acceptance is signalled while reset is held
  assign src_ready_o = arst_i ? '0 : gnt;
  assign transfer    = |src_ready_o;

  always_comb begin
    sel.addr = src_addr_i[int'(gnt_idx)*AW +: AW];
    sel.data = src_data_i[int'(gnt_idx)*DW +: DW];
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      wr_unlock_en_o   <= 1'b0;
      wr_unlock_addr_o <= '0;
      wr_unlock_data_o <= '0;
      grant_idx_o      <= '0;
    end else if (transfer) begin
      // x0 writes are consumed but never enable the register file
      wr_unlock_en_o   <= (sel.addr != '0);
      wr_unlock_addr_o <= sel.addr;
      wr_unlock_data_o <= sel.data;
      grant_idx_o      <= gnt_idx;
    end else begin
      wr_unlock_en_o   <= 1'b0;
    end
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Write-back initiator for the locking register file: collects results from NUM_SRC execution units over valid/ready ports.
- Selects at most one result per cycle and drives the register file's unlock-write port (address, data, enable) from a registered output stage.
- Sits between the execution units and the register file, so the register file receives exactly one write/unlock per cycle.

Parameters:
NUM_SRC, 4, number of execution-unit result sources (>=2)
NR, maverickOne_pkg::NUM_REGS (64), number of architectural registers (localparam)
DW, maverickOne_pkg::XLEN (64), data width (localparam)
AW, $clog2(NR), register address width (localparam)

Ports:
clk_i  in  1  clock; all flops on rising edge
arst_i  in  1  asynchronous reset, active high
src_valid_i  in  NUM_SRC  per-source result valid
src_ready_o  out  NUM_SRC  per-source accept; one-hot or zero
src_addr_i  in  NUM_SRC*AW  per-source destination register address
src_data_i  in  NUM_SRC*DW  per-source result data
wr_unlock_en_o  out  1  unlock-write enable to register file
wr_unlock_addr_o  out  AW  unlock-write address
wr_unlock_data_o  out  DW  unlock-write data
grant_idx_o  out  $clog2(NUM_SRC)  index of the source that produced the current output beat (debug/perf)

Behaviour:
- Interface decided: one clock (clk_i); reset is asynchronous and active-high (arst_i).
- Reset (asserted at any time, including mid-transfer):
  - wr_unlock_en_o=0, wr_unlock_addr_o=0, wr_unlock_data_o=0, grant_idx_o=0.
  - Round-robin pointer ptr=0.
  - src_ready_o forced to 0 while arst_i is high.
  - An in-flight output beat is discarded; no partial write reaches the register file.
- Handshake:
  - A source transfer occurs when src_valid_i[i] & src_ready_o[i] in the same cycle.
  - A source holds valid, addr and data stable until it sees ready.
  - valid must not depend on ready.
- Arbitration (combinational):
  - Grant goes to the lowest index j, searching ptr, ptr+1, ... wrapping modulo NUM_SRC, such that src_valid_i[j]=1.
  - src_ready_o = one-hot(j), or 0 if no source is valid.
  - The register file never back-pressures, so a grant is issued every cycle any source is valid.
- Pointer:
  - On a transfer from j, ptr <= (j+1) mod NUM_SRC. Wrap: j=NUM_SRC-1 sets ptr to 0.
  - No transfer: ptr holds.
- Output stage, one cycle latency (transfer in cycle N, write visible in cycle N+1):
  - wr_unlock_en_o <= transfer & (addr != 0).
  - wr_unlock_addr_o <= granted addr; wr_unlock_data_o <= granted data; grant_idx_o <= j.
  - No transfer: wr_unlock_en_o <= 0; addr/data/grant_idx hold their previous values.
- Address 0:
  - Requests to x0 are accepted, consuming a grant and advancing ptr, but produce no write enable.
- Same destination from several sources in one cycle:
  - Serialised in round-robin order over consecutive cycles; the later write wins in the register file.
- Fairness:
  - With all NUM_SRC valid continuously, each source is granted exactly once per NUM_SRC cycles.
- Throughput: 1 result/cycle sustained; no internal buffering beyond the single output register.

Optional Feature:
- Macro REGFILE_WB_FIXED_PRIO_EN.
- Defined: fixed priority; the lowest valid index always wins, and ptr is not instantiated (grant independent of history). A higher-priority source held continuously valid may starve the others; this is intended for single-cycle units placed at low indices.
- Undefined: round-robin as specified above.

Decomposition:
- maverickOne_pkg:
  - Reuses NUM_REGS and XLEN.
  - Adds typedef wb_req_t packed struct {logic [AW-1:0] addr; logic [XLEN-1:0] data;}.
  - Adds constant WB_NUM_SRC=4 as the system default for NUM_SRC.
- One sub-module, rr_arbiter: parameter N; inputs req[N], clk_i, arst_i, advance; outputs gnt one-hot and gnt_idx. It owns ptr and the wrap search, and carries the REGFILE_WB_FIXED_PRIO_EN switch.
- regfile_wb_arbiter owns the muxing and output register.

Test Plan:
- Reset: assert arst_i mid-cycle while src 2 is valid with addr 5 -> wr_unlock_en_o=0 immediately, src_ready_o=0; after release, first grant goes to src 0 if valid.
- Single source: src1 valid, addr 7, data 0xDEAD_BEEF in cycle N -> src_ready_o=4'b0010 in N; in N+1, en=1, addr=7, data=0xDEADBEEF; in N+2, en=0.
- All four valid for 8 cycles, addrs 1..4 -> grant order 0,1,2,3,0,1,2,3; each beat appears one cycle later with matching addr/data.
- x0 drop: src0 addr 0, data 0x55 -> ready asserted, ptr advances to 1, wr_unlock_en_o stays 0.
- Wrap/pointer hold: grant src3, then idle 3 cycles, then src0 and src2 valid -> src0 granted first (ptr=0 after wrap); with the macro defined, repeat src0+src2 continuously -> src0 always wins.
